// File: rtl/vga_pic_scheduler.sv
// Picture-source scheduler: turns VGA pixel requests into image-ROM reads for a
// fixed window and switches between stored pictures only at frame starts.
module vga_pic_scheduler #(
  parameter int          PIC_W      = 100,
  parameter int          PIC_H      = 100,
  parameter int          X0         = 270,
  parameter int          Y0         = 190,
  parameter int          PIC_NUM    = 4,
  parameter int          FRAME_HOLD = 120,
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] BG_COLOR   = 24'hFFFFFF,
  localparam int         IDX_W      = (PIC_NUM > 1) ? $clog2(PIC_NUM) : 1
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic              vga_request,
  input  logic [11:0]       vga_xpos,
  input  logic [11:0]       vga_ypos,
  input  logic              vga_vs,
  input  logic              pause,
  input  logic              next,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [23:0]       rom_data,
  output logic [23:0]       vga_data,
  output logic [IDX_W-1:0]  pic_idx
);

  localparam int CNT_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(FRAME_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PIC_NUM - 1);
  localparam logic [ADDR_W-1:0] PIC_STEP  = ADDR_W'(PIC_W * PIC_H);
  localparam logic [11:0]       X_LO      = 12'(X0);
  localparam logic [11:0]       X_HI      = 12'(X0 + PIC_W);
  localparam logic [11:0]       Y_LO      = 12'(Y0);
  localparam logic [11:0]       Y_HI      = 12'(Y0 + PIC_H);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               vs_d_r;
  logic               fs_s;
  logic               next_pend_r;
  logic [CNT_W-1:0]   frame_cnt_r;
  logic [IDX_W-1:0]   pic_idx_r, idx_nxt_s;
  logic [ADDR_W-1:0]  base_r, base_nxt_s;
  logic [ADDR_W-1:0]  addr_cnt_r;
  logic               advance_s, cnt_inc_s, win_en_s;
  logic               in_win_s, rd_s;
  logic               req_p1_r, win_p1_r, req_p2_r, win_p2_r;
  logic [ADDR_W-1:0]  rom_addr_r;
  logic               rom_rd_r;
  logic [23:0]        vga_data_r;

  assign fs_s     = vs_d_r & ~vga_vs;
  assign in_win_s = (vga_xpos >= X_LO) && (vga_xpos < X_HI) &&
                    (vga_ypos >= Y_LO) && (vga_ypos < Y_HI);
  assign rd_s     = vga_request & in_win_s & win_en_s;

  // Vsync history for falling-edge (frame start) detection.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) vs_d_r <= 1'b0;
    else     vs_d_r <= vga_vs;
  end

  // Slideshow state register.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next state: transitions only happen on a frame start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (fs_s)          state_nxt_s = ST_SHOW;   else state_nxt_s = ST_IDLE;
      ST_SHOW:   if (fs_s && pause)  state_nxt_s = ST_PAUSED; else state_nxt_s = ST_SHOW;
      ST_PAUSED: if (fs_s && !pause) state_nxt_s = ST_SHOW;   else state_nxt_s = ST_PAUSED;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: picture advance / hold-counter control and read enable.
  always_comb begin
    advance_s = 1'b0;
    cnt_inc_s = 1'b0;
    win_en_s  = 1'b0;
    case (state_r)
      ST_SHOW: begin
        win_en_s = 1'b1;
        if (fs_s) begin
          if ((frame_cnt_r == HOLD_LAST) || next_pend_r) advance_s = 1'b1;
          else                                           cnt_inc_s = 1'b1;
        end else begin
          advance_s = 1'b0;
          cnt_inc_s = 1'b0;
        end
      end
      ST_PAUSED: begin
        win_en_s = 1'b1;
        if (fs_s && next_pend_r) advance_s = 1'b1;
        else                     advance_s = 1'b0;
      end
      default: begin
        advance_s = 1'b0;
        cnt_inc_s = 1'b0;
        win_en_s  = 1'b0;
      end
    endcase
  end

  // Next index and its base address; the base steps by one picture so the
  // pixel path never needs a multiplier.
  always_comb begin
    idx_nxt_s  = pic_idx_r;
    base_nxt_s = base_r;
    if (advance_s) begin
      if (pic_idx_r == IDX_LAST) begin
        idx_nxt_s  = '0;
        base_nxt_s = '0;
      end else begin
        idx_nxt_s  = pic_idx_r + IDX_W'(1);
        base_nxt_s = base_r + PIC_STEP;
      end
    end else begin
      idx_nxt_s  = pic_idx_r;
      base_nxt_s = base_r;
    end
  end

  // Picture index, base, hold counter and pending manual advance.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      pic_idx_r   <= '0;
      base_r      <= '0;
      frame_cnt_r <= '0;
      next_pend_r <= 1'b0;
    end else begin
      pic_idx_r   <= idx_nxt_s;
      base_r      <= base_nxt_s;
      next_pend_r <= next | (next_pend_r & ~advance_s);
      if (advance_s)      frame_cnt_r <= '0;
      else if (cnt_inc_s) frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      else                frame_cnt_r <= frame_cnt_r;
    end
  end

  // Running ROM address: reloaded each frame start, stepped per window read.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst)       addr_cnt_r <= '0;
    else if (fs_s) addr_cnt_r <= base_nxt_s;
    else if (rd_s) addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
    else           addr_cnt_r <= addr_cnt_r;
  end

  // Stage 1 (t+1): ROM request plus the flags that ride alongside the read.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      rom_addr_r <= '0;
      rom_rd_r   <= 1'b0;
      req_p1_r   <= 1'b0;
      win_p1_r   <= 1'b0;
      req_p2_r   <= 1'b0;
      win_p2_r   <= 1'b0;
    end else begin
      rom_rd_r   <= rd_s;
      rom_addr_r <= rd_s ? addr_cnt_r : rom_addr_r;
      req_p1_r   <= vga_request;
      win_p1_r   <= rd_s;
      req_p2_r   <= req_p1_r;
      win_p2_r   <= win_p1_r;
    end
  end

  // Stage 3 (t+3): pick ROM pixel, background, or black.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst)           vga_data_r <= 24'h000000;
    else if (win_p2_r) vga_data_r <= rom_data;
    else if (req_p2_r) vga_data_r <= BG_COLOR;
    else               vga_data_r <= 24'h000000;
  end

  assign rom_addr = rom_addr_r;
  assign rom_rd   = rom_rd_r;
  assign vga_data = vga_data_r;
  assign pic_idx  = pic_idx_r;

endmodule

// File: doc/vga_pic_scheduler.md
# vga_pic_scheduler

Picture-source scheduler between the VGA timing driver and a synchronous image ROM. It turns the driver's per-pixel requests into ROM read addresses for a fixed picture window and returns pixel data with a fixed pipeline latency. It also runs a slideshow state machine that switches between `PIC_NUM` stored pictures at frame boundaries only, so no picture change ever tears mid-frame. It replaces the free-running pattern generator on the `vga_data` path in the display top level.

## Interface
- `PIC_W`, 100: picture width in pixels.
- `PIC_H`, 100: picture height in pixels.
- `X0`, 270: window left column (active-area coordinate).
- `Y0`, 190: window top row.
- `PIC_NUM`, 4: pictures stored back-to-back in ROM, each `PIC_W*PIC_H` words.
- `FRAME_HOLD`, 120: frames each picture is shown in auto mode (≥1).
- `ADDR_W`, 16: ROM address width; must satisfy `PIC_NUM*PIC_W*PIC_H ≤ 2^ADDR_W`.
- `BG_COLOR`, 24'hFFFFFF: RGB888 colour outside the window.

Ports:
- `clk_25m` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `vga_request` in 1: driver requests pixel data for (`vga_xpos`,`vga_ypos`).
- `vga_xpos` in 12: requested column, 0-based in the active area.
- `vga_ypos` in 12: requested row, 0-based in the active area.
- `vga_vs` in 1: driver vertical sync, active-low; its falling edge marks frame start.
- `pause` in 1: level; freeze auto-advance.
- `next` in 1: single-cycle pulse; advance one picture at the next frame start.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_rd` out 1: registered ROM read enable.
- `rom_data` in 24: ROM output, valid one cycle after `rom_addr`/`rom_rd`.
- `vga_data` out 24: registered RGB888 pixel to the driver.
- `pic_idx` out clog2(PIC_NUM): picture currently displayed.

## Operation
- Frame start (`fs`): a one-cycle pulse on the cycle after `vga_vs` is sampled 1 having been 0 → no, defined as the cycle after `vga_vs` is sampled 0 having been 1 (a falling edge, detected through one register).
- FSM states:
  - IDLE: after reset; outputs background/zero, no ROM reads. Goes to SHOW on the first `fs`.
  - SHOW: auto mode.
  - PAUSED: picture frozen.
- Transitions, evaluated only on `fs`:
  - SHOW → PAUSED if `pause`=1.
  - PAUSED → SHOW if `pause`=0.
- `next` pulse sets `next_pend`. `next_pend` is cleared when it is applied.
- On `fs` in SHOW:
  - If `frame_cnt==FRAME_HOLD-1` or `next_pend`: `pic_idx` advances by 1 (wraps PIC_NUM-1 → 0) and `frame_cnt` returns to 0.
  - Otherwise `frame_cnt` increments.
  - `next_pend` together with hold expiry on the same `fs` advances by exactly 1.
- On `fs` in PAUSED:
  - `frame_cnt` is held.
  - `next_pend` advances `pic_idx` by 1 and resets `frame_cnt` to 0.
- Address generation:
  - On `fs`, the running address counter loads `base = new pic_idx * PIC_W*PIC_H`. `base` is a registered value updated on each index change; no multiplier sits in the pixel path.
  - A request is in-window when `X0≤x<X0+PIC_W` and `Y0≤y<Y0+PIC_H`.
  - An in-window request issues `rom_rd`=1 with `rom_addr`=counter, then the counter increments.
  - The counter never wraps within a frame: exactly `PIC_W*PIC_H` reads occur per full frame.
- Output select (pipelined flags):
  - In-window request: `vga_data`=`rom_data`.
  - Out-of-window request: `vga_data`=`BG_COLOR`.
  - No request: `vga_data`=0.
- In IDLE, every request is treated as out-of-window.

## Timing
- Reset values: `rom_addr`=0, `rom_rd`=0, `vga_data`=0, `pic_idx`=0, `frame_cnt`=0, `next_pend`=0, state IDLE.
- Reset clears everything asynchronously. A reset asserted mid-frame gives IDLE until the next `fs` after release.
- Pipeline:
  - Request sampled in cycle t.
  - `rom_addr`/`rom_rd` valid in t+1.
  - `rom_data` valid in t+2.
  - `vga_data` valid in t+3.
  - Fixed latency is 3 cycles for all three output cases. The driver's request lead is set to 3.
- `pic_idx` updates in the cycle after `fs`. It is stable for the whole frame.
- `next` arriving in the same cycle as `fs` is latched and applied at the following `fs`.
- Throughput: one request per cycle, back-to-back, with no stalls.

## Test plan
- Reset, then one `vga_vs` fall, then a request at (270,190) → state SHOW, `pic_idx`=0, `rom_addr`=0 and `rom_rd`=1 at t+1; ROM returns 24'h123456 → `vga_data`=24'h123456 at t+3.
- With `pic_idx`=2, a full frame of requests → last window pixel (369,289) gives `rom_addr`=29999; the bench counts exactly 10000 `rom_rd` pulses.
- Request at (0,0) → `rom_rd`=0, `vga_data`=24'hFFFFFF at t+3; `vga_request`=0 → `vga_data`=0 at t+3.
- `FRAME_HOLD`=2 → `pic_idx` sequence 0,0,1,1,2,2,3,3,0 over 9 frames; `pic_idx` never changes except on the cycle after `fs`.
- `pause`=1 for 5 frames → `pic_idx` frozen. `next` pulse while paused → +1 at the next `fs`. `next` on the same `fs` as hold expiry → +1 only.
- `rst` pulsed mid-line → all outputs 0 immediately. No `rom_rd` until after the next `vga_vs` fall; then `pic_idx`=0.
